// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, sequences header/payload/parity
// loads into the selected output FIFO and stalls the source while it is full.
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  localparam logic [2:0] StDecodeAddress    = 3'd0;
  localparam logic [2:0] StLoadFirstData    = 3'd1;
  localparam logic [2:0] StWaitTillEmpty    = 3'd2;
  localparam logic [2:0] StLoadData         = 3'd3;
  localparam logic [2:0] StFifoFull         = 3'd4;
  localparam logic [2:0] StLoadAfterFull    = 3'd5;
  localparam logic [2:0] StLoadParity       = 3'd6;
  localparam logic [2:0] StCheckParityError = 3'd7;

  logic [2:0] state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic       empty_hdr;  // empty flag of the port named by the incoming header
  logic       empty_sel;  // empty flag of the latched port
  logic       soft_sel;   // timeout reset of the latched port

  // Select per-port flags by the incoming header and by the latched address.
  always_comb begin
    empty_hdr = 1'b0;
    empty_sel = 1'b0;
    soft_sel  = 1'b0;
    unique case (data_in)
      2'd0:    empty_hdr = fifo_empty_0;
      2'd1:    empty_hdr = fifo_empty_1;
      2'd2:    empty_hdr = fifo_empty_2;
      default: empty_hdr = 1'b0;
    endcase
    unique case (addr_q)
      2'd0:    begin empty_sel = fifo_empty_0; soft_sel = soft_reset_0; end
      2'd1:    begin empty_sel = fifo_empty_1; soft_sel = soft_reset_1; end
      2'd2:    begin empty_sel = fifo_empty_2; soft_sel = soft_reset_2; end
      default: begin empty_sel = 1'b0;         soft_sel = 1'b0;         end
    endcase
  end

  // Next-state and address-latch logic; a selected-port soft reset overrides all.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      StDecodeAddress: begin
        // Address 3 is invalid: the header is dropped and addr is kept.
        if (pkt_valid && (data_in != 2'b11)) begin
          addr_d  = data_in;
          state_d = empty_hdr ? StLoadFirstData : StWaitTillEmpty;
        end
      end
      StWaitTillEmpty: if (empty_sel) state_d = StLoadFirstData;
      StLoadFirstData: state_d = StLoadData;
      StLoadData: begin
        if (fifo_full)       state_d = StFifoFull;
        else if (!pkt_valid) state_d = StLoadParity;
      end
      StFifoFull: if (!fifo_full) state_d = StLoadAfterFull;
      StLoadAfterFull: begin
        if (parity_done)        state_d = StDecodeAddress;
        else if (low_pkt_valid) state_d = StLoadParity;
        else                    state_d = StLoadData;
      end
      StLoadParity:       state_d = StCheckParityError;
      StCheckParityError: state_d = fifo_full ? StFifoFull : StDecodeAddress;
      default:            state_d = StDecodeAddress;
    endcase
    if (soft_sel) state_d = StDecodeAddress;
  end

  // State and address registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StDecodeAddress;
      addr_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    detect_add    = (state_q == StDecodeAddress);
    lfd_state     = (state_q == StLoadFirstData);
    ld_state      = (state_q == StLoadData);
    laf_state     = (state_q == StLoadAfterFull);
    full_state    = (state_q == StFifoFull);
    rst_int_reg   = (state_q == StCheckParityError);
    write_enb_reg = (state_q == StLoadData) || (state_q == StLoadParity) ||
                    (state_q == StLoadAfterFull);
    busy          = !((state_q == StDecodeAddress) || (state_q == StLoadData));
  end

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed vector table, hand-written reset sequences and a
// randomized run checked against a behavioural packet-phase model.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, busy;
  logic [7:0] dut_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  router_fsm dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .write_enb_reg (write_enb_reg),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy)
  );

  // {write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy}
  assign dut_out = {write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
                    full_state, rst_int_reg, busy};

  localparam logic [7:0] ODec  = 8'b0100_0000;
  localparam logic [7:0] OLfd  = 8'b0010_0001;
  localparam logic [7:0] OWait = 8'b0000_0001;
  localparam logic [7:0] OLd   = 8'b1001_0000;
  localparam logic [7:0] OFull = 8'b0000_0101;
  localparam logic [7:0] OLaf  = 8'b1000_1001;
  localparam logic [7:0] OPar  = 8'b1000_0001;
  localparam logic [7:0] OChk  = 8'b0000_0011;

  // Behavioural model: phase of the packet being routed plus the chosen port.
  typedef enum int {PDec, PLfd, PWait, PLoad, PFull, PLaf, PPar, PChk} phase_e;
  phase_e m_phase;
  int     m_port;

  function automatic logic [7:0] model_out(phase_e p);
    logic we, bz;
    we = (p == PLoad) || (p == PPar) || (p == PLaf);
    bz = !((p == PDec) || (p == PLoad));
    return {we, p == PDec, p == PLfd, p == PLoad, p == PLaf, p == PFull, p == PChk, bz};
  endfunction

  task automatic model_reset();
    m_phase = PDec;
    m_port  = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [2:0] emp, sr;
    phase_e     nxt;
    int         port;
    emp  = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    sr   = {soft_reset_2, soft_reset_1, soft_reset_0};
    nxt  = m_phase;
    port = m_port;
    case (m_phase)
      PDec:  if (pkt_valid && int'(data_in) < 3) begin
               port = int'(data_in);
               nxt  = emp[port] ? PLfd : PWait;
             end
      PWait: if (emp[m_port]) nxt = PLfd;
      PLfd:  nxt = PLoad;
      PLoad: nxt = fifo_full ? PFull : (!pkt_valid ? PPar : PLoad);
      PFull: if (!fifo_full) nxt = PLaf;
      PLaf:  nxt = parity_done ? PDec : (low_pkt_valid ? PPar : PLoad);
      PPar:  nxt = PChk;
      PChk:  nxt = fifo_full ? PFull : PDec;
      default: nxt = PDec;
    endcase
    if (sr[m_port]) nxt = PDec;
    m_phase = nxt;
    m_port  = port;
  endtask

  task automatic check(string name, logic [7:0] got, logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic apply(bit pv, bit [1:0] din, bit full, bit [2:0] emp, bit [2:0] sr,
                       bit pd, bit lpv);
    pkt_valid     = pv;
    data_in       = din;
    fifo_full     = full;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = emp;
    {soft_reset_2, soft_reset_1, soft_reset_0} = sr;
    parity_done   = pd;
    low_pkt_valid = lpv;
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    bit       pv;
    bit [1:0] din;
    bit       full;
    bit [2:0] emp;
    bit [2:0] sr;
    bit       pd;
    bit       lpv;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit pv, bit [1:0] din, bit full, bit [2:0] emp, bit [2:0] sr,
                              bit pd, bit lpv, logic [7:0] exp);
    vec_t v;
    v.pv = pv; v.din = din; v.full = full; v.emp = emp; v.sr = sr;
    v.pd = pd; v.lpv = lpv; v.exp = exp;
    return v;
  endfunction

  initial begin
    // Directed sequence, each row: inputs before the edge, outputs after it.
    vecs.push_back(mk(1, 2'd1, 0, 3'b010, 3'b000, 0, 0, OLfd));   // header to port 1
    vecs.push_back(mk(1, 2'd1, 0, 3'b010, 3'b000, 0, 0, OLd));
    vecs.push_back(mk(1, 2'd1, 0, 3'b010, 3'b000, 0, 0, OLd));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b000, 0, 0, OPar));   // pkt_valid drops
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b000, 0, 0, OChk));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b000, 0, 0, ODec));
    vecs.push_back(mk(1, 2'd2, 0, 3'b000, 3'b000, 0, 0, OWait));  // port 2 not empty
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 2'd0, 0, 3'b011, 3'b000, 0, 0, OWait));
    vecs.push_back(mk(0, 2'd0, 0, 3'b100, 3'b000, 0, 0, OLfd));
    vecs.push_back(mk(1, 2'd0, 0, 3'b000, 3'b000, 0, 0, OLd));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 2'd0, 1, 3'b000, 3'b000, 0, 0, OFull));
    vecs.push_back(mk(1, 2'd0, 0, 3'b000, 3'b000, 0, 0, OLaf));
    vecs.push_back(mk(1, 2'd0, 0, 3'b000, 3'b000, 0, 0, OLd));    // LAF -> LOAD_DATA
    vecs.push_back(mk(1, 2'd0, 1, 3'b000, 3'b000, 0, 0, OFull));
    vecs.push_back(mk(1, 2'd0, 0, 3'b000, 3'b000, 0, 0, OLaf));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b000, 0, 1, OPar));   // LAF -> LOAD_PARITY
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b000, 0, 0, OChk));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b000, 0, 0, ODec));
    vecs.push_back(mk(1, 2'd0, 0, 3'b001, 3'b000, 0, 0, OLfd));
    vecs.push_back(mk(1, 2'd0, 0, 3'b000, 3'b000, 0, 0, OLd));
    vecs.push_back(mk(1, 2'd0, 1, 3'b000, 3'b000, 0, 0, OFull));
    vecs.push_back(mk(1, 2'd0, 0, 3'b000, 3'b000, 0, 0, OLaf));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b000, 1, 1, ODec));   // parity_done wins
    vecs.push_back(mk(1, 2'd0, 0, 3'b000, 3'b000, 0, 0, OWait));  // addr 0, not empty
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b010, 0, 0, OWait));  // other port ignored
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b001, 0, 0, ODec));   // own soft reset
    vecs.push_back(mk(1, 2'd0, 0, 3'b001, 3'b000, 0, 0, OLfd));
    vecs.push_back(mk(1, 2'd0, 0, 3'b000, 3'b000, 0, 0, OLd));
    vecs.push_back(mk(0, 2'd0, 1, 3'b000, 3'b000, 0, 0, OFull));  // full beats !pkt_valid
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b000, 0, 0, OLaf));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b000, 0, 1, OPar));
    vecs.push_back(mk(0, 2'd0, 1, 3'b000, 3'b000, 0, 0, OChk));   // LP is unconditional
    vecs.push_back(mk(0, 2'd0, 1, 3'b000, 3'b000, 0, 0, OFull));  // CPE with full
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b000, 0, 0, OLaf));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b000, 1, 0, ODec));
    vecs.push_back(mk(1, 2'd1, 0, 3'b000, 3'b000, 0, 0, OWait));  // addr 1
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b010, 0, 0, ODec));
    vecs.push_back(mk(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, ODec));   // invalid header dropped
    // addr must still be 1: soft_reset_1 blocks this header to empty port 0
    vecs.push_back(mk(1, 2'd0, 0, 3'b001, 3'b010, 0, 0, ODec));
    vecs.push_back(mk(1, 2'd0, 0, 3'b001, 3'b000, 0, 0, OLfd));
    vecs.push_back(mk(1, 2'd0, 0, 3'b000, 3'b010, 0, 0, OLd));    // port 1 reset ignored
    vecs.push_back(mk(1, 2'd0, 1, 3'b000, 3'b001, 0, 0, ODec));   // soft reset beats full

    apply(0, 2'd0, 0, 3'b000, 3'b000, 0, 0);
    resetn = 1'b0;
    #3;
    model_reset();
    check("reset_state", dut_out, ODec);
    check("reset_model", model_out(m_phase), ODec);
    #8 resetn = 1'b1;  // released mid-cycle, before the edge at t=15
    @(posedge clock);
    #1;
    check("hold_after_reset", dut_out, ODec);

    foreach (vecs[i]) begin
      apply(vecs[i].pv, vecs[i].din, vecs[i].full, vecs[i].emp, vecs[i].sr,
            vecs[i].pd, vecs[i].lpv);
      step();
      check($sformatf("vec%0d", i), dut_out, vecs[i].exp);
    end

    // Mid-packet asynchronous reset, no clock edge needed.
    apply(1, 2'd2, 0, 3'b100, 3'b000, 0, 0);
    step();
    check("seq_lfd", dut_out, OLfd);
    step();
    check("seq_ld", dut_out, OLd);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check("async_reset", dut_out, ODec);
    apply(1, 2'd1, 0, 3'b111, 3'b000, 0, 0);
    @(posedge clock);
    #1;
    check("reset_held", dut_out, ODec);
    resetn = 1'b1;
    step();
    check("first_edge_after_reset", dut_out, OLfd);

    // Randomized run against the model, with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      apply($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
            {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 15) == 0},
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 249) == 0) begin
        resetn = 1'b0;
        #1;
        model_reset();
        check("rand_async_reset", dut_out, ODec);
        #2 resetn = 1'b1;
      end
      step();
      check($sformatf("rand%0d", c), dut_out, model_out(m_phase));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
